// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package prog_loader_pkg;

  localparam int FIELD_W = 8;
  localparam logic [FIELD_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Loads a framed byte stream (SYNC, LEN, data, CSUM) into instruction memory
// and holds the core in reset until a frame with a matching checksum is stored.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                 ADDR_W = 4,
  parameter logic [FIELD_W-1:0] SYNC   = SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FIELD_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [FIELD_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic               busy
);

  // cnt must hold the full depth, one more than the largest address
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [FIELD_W:0] DEPTH = (FIELD_W + 1)'(2 ** ADDR_W);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [FIELD_W-1:0] acc;
  logic [ADDR_W-1:0]  addr;
  logic               accept;

  // Stall the stream while a write is on the port, so DATA takes at most one byte per two cycles.
  assign in_ready = !mem_we && (state != S_DONE) && (state != S_ERR);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;

  // NOTE: every register here uses <= so all updates see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && in_data == SYNC) begin
            state     <= S_LEN;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_hold  <= 1'b1;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (in_data == '0 || {1'b0, in_data} > DEPTH) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else begin
              state <= S_DATA;
              cnt   <= in_data[CNT_W-1:0];
              acc   <= in_data;
              addr  <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_wdata <= in_data;
            mem_addr  <= addr;
            addr      <= addr + 1'b1;
            acc       <= acc + in_data;
            cnt       <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == acc) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writes a program image into the 8-bit processor's instruction memory from a framed byte stream, and holds the core in reset until a valid image has been stored. It is the writer side of the instruction-memory interface; the processor core is the reader. It sits in tt_um_myprocessor between the external byte source and the imem write port.

Parameters:
ADDR_W, 4, instruction-memory address width; depth = 2**ADDR_W, which must be 255 or less.
SYNC, 8'hA5, frame start byte.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte when in_valid and in_ready are both high
mem_we  out  1  imem write strobe
mem_addr  out  ADDR_W  imem write address
mem_wdata  out  8  imem write data
cpu_hold  out  1  high keeps the processor core in reset
load_done  out  1  sticky: last frame stored and checksum matched
load_err  out  1  sticky: last frame rejected
busy  out  1  frame in progress (any state except IDLE)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state is updated on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, busy=0.
- Frame format: SYNC, LEN, LEN data bytes, CSUM. CSUM = (LEN + sum of data bytes) mod 256.
- A byte is accepted only in a cycle where in_valid and in_ready are both high.
- States:
  - IDLE: accepted byte == SYNC goes to LEN; clears load_done and load_err; sets cpu_hold=1. Any other byte is discarded.
  - LEN: LEN==0 or LEN>2**ADDR_W goes to ERR. Otherwise store cnt=LEN, acc=LEN, addr=0, and go to DATA.
  - DATA: accepted byte b registers mem_we=1, mem_wdata=b, mem_addr=addr in the next cycle (1-cycle write latency); acc+=b; addr+=1; cnt-=1. When cnt reaches 0, go to CSUM.
  - CSUM: byte == acc goes to DONE; otherwise goes to ERR.
  - DONE: load_done=1, cpu_hold=0; state returns to IDLE the next cycle.
  - ERR: load_err=1, cpu_hold stays 1; state returns to IDLE the next cycle.
- in_ready: deasserted in the cycle mem_we is high, so DATA accepts at most one byte per 2 cycles. Also deasserted in DONE and ERR. High otherwise.
- mem_we is a single-cycle pulse. mem_addr/mem_wdata hold their last value when mem_we=0.
- addr never wraps: the LEN check guarantees the highest address written is 2**ADDR_W-1.
- A SYNC byte received mid-frame (in DATA) is treated as data. There is no resynchronisation inside a frame.
- Memory written before an ERR is not rolled back; cpu_hold=1 keeps the partial image from executing.
- rst asserted mid-frame aborts the frame; no further mem_we is issued after the reset edge.
- acc arithmetic is 8-bit with wrap-around.
- After DONE, a new SYNC re-asserts cpu_hold and starts a reload.

Decomposition:
- Shared package: state enum (IDLE, LEN, DATA, CSUM, DONE, ERR), SYNC default, frame-field width constant 8.
- No sub-module needed. The checksum accumulator is inline.

Test Plan:
- Reset: hold rst high 2 cycles -> cpu_hold=1, in_ready=1, mem_we=0, load_done=0, load_err=0.
- Good frame A5,03,11,22,33,69 -> writes (0,11),(1,22),(2,33), each mem_we 1 cycle after its byte; in_ready low during each write; then load_done=1, cpu_hold=0.
- Bad checksum A5,02,01,02,00 -> two writes, then load_err=1, cpu_hold=1, load_done=0.
- Length bounds with ADDR_W=4: LEN=00 -> ERR, no writes; LEN=11h -> ERR, no writes; LEN=10h with a correct CSUM -> 16 writes at addr 0..F, load_done=1.
- Garbage bytes 00,FF,5A before A5,01,7F,80 -> garbage ignored; write (0,7F); load_done=1. in_valid toggled randomly throughout -> identical result.
- rst pulsed after the 2nd data byte of a 4-byte frame -> no further writes, reset values restored; the following good frame loads correctly.
